pool_wb_arbiter: RTL

POOL_WB_ARBITER -- requirements
Module: pool_wb_arbiter

---
 rtl/pool_wb_arbiter_pkg.sv | 30 +++
 rtl/pool_wb_arbiter_if.sv | 28 ++
 rtl/pool_wb_fifo.sv | 43 ++++
 rtl/pool_wb_arbiter.sv | 126 ++++++++++++
 4 files changed

// File: rtl/pool_wb_arbiter_pkg.sv
// Shared definitions for the pooling write-back arbiter: default lane/width
// macros, the lane entry layout and a small index-width helper.
`ifndef POOL_NUM
`define POOL_NUM 4
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 12
`endif

package pool_wb_arbiter_pkg;

  localparam int unsigned POOL_NUM_DEF   = `POOL_NUM;
  localparam int unsigned DATA_WIDTH_DEF = `DATA_WIDTH;
  localparam int unsigned ADDR_WIDTH_DEF = `ADDRESS_WIDTH;

  typedef struct packed {
    logic                      last;
    logic [ADDR_WIDTH_DEF-1:0] addr;
    logic [DATA_WIDTH_DEF-1:0] data;
  } lane_entry_t;

  // Width of a lane index; never zero so single-lane builds still elaborate.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pool_wb_arbiter_if.sv
// Bus bundle between the pooling lanes and the ifmap buffer write port.
interface pool_wb_arbiter_if #(
  parameter int unsigned POOL_NUM      = `POOL_NUM,
  parameter int unsigned DATA_WIDTH    = `DATA_WIDTH,
  parameter int unsigned ADDRESS_WIDTH = `ADDRESS_WIDTH
);

  logic [POOL_NUM-1:0]                    pool_valid_i;
  logic [POOL_NUM-1:0]                    pool_last_i;
  logic [POOL_NUM-1:0][DATA_WIDTH-1:0]    pool_result_i;
  logic [POOL_NUM-1:0][ADDRESS_WIDTH-1:0] pool_result_address_i;
  logic                                   wr_en_o;
  logic [ADDRESS_WIDTH-1:0]               wr_addr_o;
  logic [DATA_WIDTH-1:0]                  wr_data_o;
  logic                                   layer_done_o;
  logic [POOL_NUM-1:0]                    overflow_o;

  modport master (
    output pool_valid_i, pool_last_i, pool_result_i, pool_result_address_i,
    input  wr_en_o, wr_addr_o, wr_data_o, layer_done_o, overflow_o
  );

  modport slave (
    input  pool_valid_i, pool_last_i, pool_result_i, pool_result_address_i,
    output wr_en_o, wr_addr_o, wr_data_o, layer_done_o, overflow_o
  );

endinterface

// File: rtl/pool_wb_fifo.sv
// Per-lane synchronous FIFO; a push while full is accepted only alongside a pop.
module pool_wb_fifo #(
  parameter int unsigned WIDTH = 21,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic             full_c,
  output logic             empty_c,
  output logic [WIDTH-1:0] dout_c
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [PW:0]      wptr_q, rptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  // Extra pointer bit distinguishes full from empty.
  assign empty_c = (wptr_q == rptr_q);
  assign full_c  = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
  assign do_pop  = pop_i & ~empty_c;
  assign do_push = push_i & (~full_c | do_pop);
  assign dout_c  = mem_q[rptr_q[PW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + (PW+1)'(1);
      if (do_pop)  rptr_q <= rptr_q + (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[PW-1:0]] <= din_i;
  end

endmodule

// File: rtl/pool_wb_arbiter.sv
// Round-robin write-back arbiter: drains per-lane result FIFOs into the ifmap
// buffer one word per cycle. POOL_WB_BASE_ADDR_EN adds a base_addr_i offset.
module pool_wb_arbiter
  import pool_wb_arbiter_pkg::*;
#(
  parameter int unsigned POOL_NUM      = `POOL_NUM,
  parameter int unsigned DATA_WIDTH    = `DATA_WIDTH,
  parameter int unsigned ADDRESS_WIDTH = `ADDRESS_WIDTH,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input logic                     clk,
  input logic                     rst,
`ifdef POOL_WB_BASE_ADDR_EN
  input logic [ADDRESS_WIDTH-1:0] base_addr_i,
`endif
  pool_wb_arbiter_if.slave        bus
);

  localparam int unsigned LW = idx_w(POOL_NUM);
  localparam int unsigned EW = 1 + ADDRESS_WIDTH + DATA_WIDTH;

  logic [POOL_NUM-1:0]          full, empty, pop;
  logic [POOL_NUM-1:0][EW-1:0]  din, dout;
  logic [LW-1:0]                rr_q, rr_d, gnt_idx;
  logic                         gnt_vld;
  logic [EW-1:0]                sel;
  logic                         sel_last;
  logic [ADDRESS_WIDTH-1:0]     sel_addr;
  logic [DATA_WIDTH-1:0]        sel_data;
  logic                         wr_en_q, wr_last_q, layer_done_q, layer_done_d;
  logic [ADDRESS_WIDTH-1:0]     wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0]        wr_data_q;
  logic [LW-1:0]                wr_lane_q;
  logic [POOL_NUM-1:0]          done_q, done_d, done_set, ovf_q, ovf_d;

  for (genvar g = 0; g < POOL_NUM; g++) begin : g_lane
    assign din[g] = {bus.pool_last_i[g], bus.pool_result_address_i[g], bus.pool_result_i[g]};

    pool_wb_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (bus.pool_valid_i[g] & ~rst),
      .pop_i   (pop[g]),
      .din_i   (din[g]),
      .full_c  (full[g]),
      .empty_c (empty[g]),
      .dout_c  (dout[g])
    );
  end

  // Grant search begins at the lane after the previous winner.
  always_comb begin
    int unsigned lane;
    lane    = 0;
    gnt_vld = 1'b0;
    gnt_idx = rr_q;
    pop     = '0;
    for (int unsigned k = 1; k <= POOL_NUM; k++) begin
      lane = (32'(rr_q) + k) % POOL_NUM;
      if (!gnt_vld && !empty[LW'(lane)]) begin
        gnt_vld = 1'b1;
        gnt_idx = LW'(lane);
      end
    end
    if (gnt_vld) pop[gnt_idx] = 1'b1;
    rr_d = gnt_vld ? gnt_idx : rr_q;
  end

  assign sel      = dout[gnt_idx];
  assign sel_last = sel[EW-1];
  assign sel_addr = sel[DATA_WIDTH +: ADDRESS_WIDTH];
  assign sel_data = sel[DATA_WIDTH-1:0];

`ifdef POOL_WB_BASE_ADDR_EN
  assign wr_addr_d = sel_addr + base_addr_i;
`else
  assign wr_addr_d = sel_addr;
`endif

  // Done flags track the word currently on the write port; all-set pulses and clears.
  always_comb begin
    done_set = '0;
    if (wr_en_q && wr_last_q) done_set[wr_lane_q] = 1'b1;
    done_d       = done_q | done_set;
    layer_done_d = 1'b0;
    if (&done_d) begin
      layer_done_d = 1'b1;
      done_d       = '0;
    end
  end

  assign ovf_d = ovf_q | (bus.pool_valid_i & full & ~pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q         <= LW'(POOL_NUM - 1);
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      wr_last_q    <= 1'b0;
      wr_lane_q    <= '0;
      done_q       <= '0;
      layer_done_q <= 1'b0;
      ovf_q        <= '0;
    end else begin
      rr_q    <= rr_d;
      wr_en_q <= gnt_vld;
      if (gnt_vld) begin
        wr_addr_q <= wr_addr_d;
        wr_data_q <= sel_data;
        wr_last_q <= sel_last;
        wr_lane_q <= gnt_idx;
      end
      done_q       <= done_d;
      layer_done_q <= layer_done_d;
      ovf_q        <= ovf_d;
    end
  end

  assign bus.wr_en_o      = wr_en_q;
  assign bus.wr_addr_o    = wr_addr_q;
  assign bus.wr_data_o    = wr_data_q;
  assign bus.layer_done_o = layer_done_q;
  assign bus.overflow_o   = ovf_q;

endmodule
